// File: rtl/procb_state_seq_pkg.sv
// Shared widths, FSM encoding and save-word helper for the process_bytes state sequencer.
// Optional macro PROCB_BYPASS_EN (consumed by the top) enables write-to-read forwarding.
package procb_state_seq_pkg;

  localparam int PROCB_TOTAL_WIDTH = 16;
  localparam int PROCB_REC_WIDTH   = 32;
  localparam int PROCB_SAVE_WIDTH  = PROCB_TOTAL_WIDTH + PROCB_REC_WIDTH;
  localparam int SAVE_INC_WIDTH    = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_OUT  = 2'd2,
    ST_BUSY = 2'd3
  } state_e;

  function automatic logic [PROCB_SAVE_WIDTH-1:0] pack_save(
    input logic [PROCB_TOTAL_WIDTH-1:0] total,
    input logic [PROCB_REC_WIDTH-1:0]   rec
  );
    return {total, rec};
  endfunction

endpackage

// File: rtl/procb_state_seq_if.sv
// Scheduler, engine, completion and saved-state memory signals of the sequencer.
// slave = sequencer side, master = surrounding environment.
interface procb_state_seq_if
  import procb_state_seq_pkg::*;
#(
  parameter int N_THREADS = 8
) ();
  localparam int TN_W = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;

  logic                         req_valid;
  logic                         req_ready;
  logic [TN_W-1:0]              req_thread_num;
  logic                         req_new;
  logic                         out_valid;
  logic                         out_ready;
  logic [TN_W-1:0]              out_thread_num;
  logic [PROCB_TOTAL_WIDTH-1:0] out_total;
  logic [PROCB_REC_WIDTH-1:0]   out_rec;
  logic                         save_valid;
  logic                         save_last;
  logic [SAVE_INC_WIDTH-1:0]    save_inc;
  logic [PROCB_REC_WIDTH-1:0]   save_rec;
  logic                         done;
  logic [TN_W-1:0]              done_thread_num;
  logic [PROCB_TOTAL_WIDTH-1:0] done_total;
  logic                         err_overflow;
  logic                         mem_rd_en;
  logic [TN_W-1:0]              mem_rd_thread_num;
  logic [PROCB_SAVE_WIDTH-1:0]  mem_dout;
  logic                         mem_wr_en;
  logic [TN_W-1:0]              mem_wr_thread_num;
  logic [PROCB_SAVE_WIDTH-1:0]  mem_din;

  modport slave (
    input  req_valid, req_thread_num, req_new, out_ready,
    input  save_valid, save_last, save_inc, save_rec, mem_dout,
    output req_ready, out_valid, out_thread_num, out_total, out_rec,
    output done, done_thread_num, done_total, err_overflow,
    output mem_rd_en, mem_rd_thread_num, mem_wr_en, mem_wr_thread_num, mem_din
  );

  modport master (
    output req_valid, req_thread_num, req_new, out_ready,
    output save_valid, save_last, save_inc, save_rec, mem_dout,
    input  req_ready, out_valid, out_thread_num, out_total, out_rec,
    input  done, done_thread_num, done_total, err_overflow,
    input  mem_rd_en, mem_rd_thread_num, mem_wr_en, mem_wr_thread_num, mem_din
  );

endinterface

// File: rtl/procb_state_seq_total_add.sv
// bytes_total adder: combinational modular sum plus a sticky overflow flag
// set whenever an enabled addition carries out of the total width.
module procb_state_seq_total_add
  import procb_state_seq_pkg::*;
(
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         en_i,
  input  logic [PROCB_TOTAL_WIDTH-1:0] total_i,
  input  logic [SAVE_INC_WIDTH-1:0]    inc_i,
  output logic [PROCB_TOTAL_WIDTH-1:0] sum_o,
  output logic                         overflow_o
);
  logic [PROCB_TOTAL_WIDTH:0] wide_s;
  logic                       overflow_q;

  always_comb begin
    wide_s = {1'b0, total_i} + {{(PROCB_TOTAL_WIDTH + 1 - SAVE_INC_WIDTH){1'b0}}, inc_i};
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      overflow_q <= 1'b0;
    end else if (en_i && wide_s[PROCB_TOTAL_WIDTH]) begin
      overflow_q <= 1'b1;
    end else begin
      overflow_q <= overflow_q;
    end
  end

  assign sum_o      = wide_s[PROCB_TOTAL_WIDTH-1:0];
  assign overflow_o = overflow_q;

endmodule

// File: rtl/procb_state_seq.sv
// Per-thread saved-state sequencer for the process_bytes stage (one thread in flight).
// Define PROCB_BYPASS_EN to forward a pending write into the next read (no turnaround bubble).
module procb_state_seq
  import procb_state_seq_pkg::*;
#(
  parameter int N_THREADS = 8
) (
  input logic                CLK,
  input logic                RESET_N,
  procb_state_seq_if.slave   bus
);
  localparam int TN_W = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;

  state_e                       state_q;
  logic [TN_W-1:0]              thread_q;
  logic                         out_valid_q;
  logic [PROCB_TOTAL_WIDTH-1:0] out_total_q;
  logic [PROCB_REC_WIDTH-1:0]   out_rec_q;
  logic                         done_q;
  logic [TN_W-1:0]              done_thread_q;
  logic [PROCB_TOTAL_WIDTH-1:0] done_total_q;
  logic                         mem_wr_en_q;
  logic [TN_W-1:0]              mem_wr_thread_q;
  logic [PROCB_SAVE_WIDTH-1:0]  mem_din_q;
  logic [PROCB_TOTAL_WIDTH-1:0] new_total_s;
  logic                         overflow_s;
  logic                         save_fire_s;
  logic                         req_ready_s;
  logic                         req_fire_s;
`ifdef PROCB_BYPASS_EN
  logic                         fwd_hit_q;
`endif

  assign save_fire_s = (state_q == ST_BUSY) && bus.save_valid;

  procb_state_seq_total_add u_total_add (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .en_i       (save_fire_s),
    .total_i    (out_total_q),
    .inc_i      (bus.save_inc),
    .sum_o      (new_total_s),
    .overflow_o (overflow_s)
  );

  // Without forwarding, a read on the edge of a pending write would return stale data.
  always_comb begin
    req_ready_s = 1'b0;
`ifdef PROCB_BYPASS_EN
    req_ready_s = RESET_N && (state_q == ST_IDLE);
`else
    req_ready_s = RESET_N && (state_q == ST_IDLE) && !mem_wr_en_q;
`endif
    req_fire_s = bus.req_valid && req_ready_s;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q         <= ST_IDLE;
      thread_q        <= '0;
      out_valid_q     <= 1'b0;
      out_total_q     <= '0;
      out_rec_q       <= '0;
      done_q          <= 1'b0;
      done_thread_q   <= '0;
      done_total_q    <= '0;
      mem_wr_en_q     <= 1'b0;
      mem_wr_thread_q <= '0;
      mem_din_q       <= '0;
`ifdef PROCB_BYPASS_EN
      fwd_hit_q       <= 1'b0;
`endif
    end else begin
      mem_wr_en_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_fire_s) begin
            thread_q <= bus.req_thread_num;
            if (bus.req_new) begin
              out_total_q <= '0;
              out_rec_q   <= '0;
              out_valid_q <= 1'b1;
              state_q     <= ST_OUT;
            end else begin
`ifdef PROCB_BYPASS_EN
              fwd_hit_q <= mem_wr_en_q && (mem_wr_thread_q == bus.req_thread_num);
`endif
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
`ifdef PROCB_BYPASS_EN
          if (fwd_hit_q) begin
            {out_total_q, out_rec_q} <= mem_din_q;
          end else begin
            {out_total_q, out_rec_q} <= bus.mem_dout;
          end
`else
          {out_total_q, out_rec_q} <= bus.mem_dout;
`endif
          out_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus.save_valid) begin
            mem_wr_en_q     <= 1'b1;
            mem_wr_thread_q <= thread_q;
            if (bus.save_last) begin
              mem_din_q     <= '0;
              done_q        <= 1'b1;
              done_total_q  <= new_total_s;
              done_thread_q <= thread_q;
            end else begin
              mem_din_q <= pack_save(new_total_s, bus.save_rec);
            end
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready         = req_ready_s;
  assign bus.mem_rd_en         = req_fire_s && !bus.req_new;
  assign bus.mem_rd_thread_num = bus.req_thread_num;
  assign bus.out_valid         = out_valid_q;
  assign bus.out_thread_num    = thread_q;
  assign bus.out_total         = out_total_q;
  assign bus.out_rec           = out_rec_q;
  assign bus.done              = done_q;
  assign bus.done_thread_num   = done_thread_q;
  assign bus.done_total        = done_total_q;
  assign bus.err_overflow      = overflow_s;
  assign bus.mem_wr_en         = mem_wr_en_q;
  assign bus.mem_wr_thread_num = mem_wr_thread_q;
  assign bus.mem_din           = mem_din_q;

endmodule

// File: tb/tb_procb_state_seq.sv
// Directed self-checking bench for procb_state_seq with a registered-read saved-state memory model.
module tb_procb_state_seq;
  import procb_state_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  logic [47:0] mem [8];
  logic        pre_en;
  logic [2:0]  pre_addr;
  logic [47:0] pre_data;

  procb_state_seq_if #(.N_THREADS(8)) bus ();

  procb_state_seq #(.N_THREADS(8)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Saved-state memory: write and registered read on the same edge return the old word.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.mem_wr_en) mem[bus.mem_wr_thread_num] <= bus.mem_din;
    if (bus.mem_rd_en) bus.mem_dout <= mem[bus.mem_rd_thread_num];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [2:0] a, input logic [47:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_en = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; pre_en = 1'b0; pre_addr = 3'd0; pre_data = 48'd0;
    bus.req_valid = 1'b0; bus.req_thread_num = 3'd0; bus.req_new = 1'b0;
    bus.out_ready = 1'b0; bus.save_valid = 1'b0; bus.save_last = 1'b0;
    bus.save_inc = 7'd0; bus.save_rec = 32'd0; bus.mem_dout = 48'd0;
    for (int i = 0; i < 8; i++) preload(i[2:0], 48'd0);
    preload(3'd5, {16'h1111, 32'hAAAAAAAA});
    preload(3'd2, {16'hFFF6, 32'h00000000});

    chk("rst_req_ready", bus.req_ready, 48'd0);
    chk("rst_out_valid", bus.out_valid, 48'd0);
    chk("rst_out_total", bus.out_total, 48'd0);
    chk("rst_done_total", bus.done_total, 48'd0);
    chk("rst_wr_en", bus.mem_wr_en, 48'd0);
    chk("rst_err", bus.err_overflow, 48'd0);
    rst_n = 1'b1;
    step();
    chk("idle_ready", bus.req_ready, 48'd1);

    // Fresh request, thread 3
    bus.req_valid = 1'b1; bus.req_thread_num = 3'd3; bus.req_new = 1'b1;
    #1;
    chk("fresh_no_rd", bus.mem_rd_en, 48'd0);
    step();
    bus.req_valid = 1'b0;
    chk("fresh_out_valid", bus.out_valid, 48'd1);
    chk("fresh_out_thread", bus.out_thread_num, 48'd3);
    chk("fresh_out_total", bus.out_total, 48'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("fresh_busy_nov", bus.out_valid, 48'd0);
    bus.save_valid = 1'b1; bus.save_last = 1'b0; bus.save_inc = 7'd64; bus.save_rec = 32'hDEADBEEF;
    step();
    bus.save_valid = 1'b0;
    chk("fresh_wr_en", bus.mem_wr_en, 48'd1);
    chk("fresh_wr_thread", bus.mem_wr_thread_num, 48'd3);
    chk("fresh_din", bus.mem_din, {16'd64, 32'hDEADBEEF});
    chk("fresh_no_done", bus.done, 48'd0);
`ifdef PROCB_BYPASS_EN
    chk("fresh_s1_ready", bus.req_ready, 48'd1);
`else
    chk("fresh_s1_ready", bus.req_ready, 48'd0);
`endif
    step();
    chk("fresh_wr_pulse", bus.mem_wr_en, 48'd0);

    // Resume thread 3, finish record
    bus.req_valid = 1'b1; bus.req_thread_num = 3'd3; bus.req_new = 1'b0;
    #1;
    chk("res_rd_en", bus.mem_rd_en, 48'd1);
    chk("res_rd_thread", bus.mem_rd_thread_num, 48'd3);
    step();
    bus.req_valid = 1'b0;
    chk("res_read_nov", bus.out_valid, 48'd0);
    step();
    chk("res_out_valid", bus.out_valid, 48'd1);
    chk("res_out_total", bus.out_total, 48'd64);
    chk("res_out_rec", bus.out_rec, 48'hDEADBEEF);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    bus.save_valid = 1'b1; bus.save_last = 1'b1; bus.save_inc = 7'd23; bus.save_rec = 32'h55555555;
    step();
    bus.save_valid = 1'b0;
    chk("res_done", bus.done, 48'd1);
    chk("res_done_total", bus.done_total, 48'd87);
    chk("res_done_thread", bus.done_thread_num, 48'd3);
    chk("res_din_zero", bus.mem_din, 48'd0);
    chk("res_wr_en", bus.mem_wr_en, 48'd1);
    step();
    chk("res_done_pulse", bus.done, 48'd0);
    chk("res_done_hold", bus.done_total, 48'd87);

    // Back-to-back on thread 5 (memory holds a stale word)
    bus.req_valid = 1'b1; bus.req_thread_num = 3'd5; bus.req_new = 1'b1;
    step();
    bus.req_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    bus.save_valid = 1'b1; bus.save_last = 1'b0; bus.save_inc = 7'd40; bus.save_rec = 32'h12345678;
    step();
    bus.save_valid = 1'b0;
    bus.req_valid = 1'b1; bus.req_thread_num = 3'd5; bus.req_new = 1'b0;
    #1;
`ifdef PROCB_BYPASS_EN
    chk("b2b_s1_ready", bus.req_ready, 48'd1);
`else
    chk("b2b_s1_ready", bus.req_ready, 48'd0);
`endif
    step();
`ifndef PROCB_BYPASS_EN
    chk("b2b_s2_ready", bus.req_ready, 48'd1);
    step();
`endif
    bus.req_valid = 1'b0;
    step();
    chk("b2b_out_valid", bus.out_valid, 48'd1);
    chk("b2b_out_total", bus.out_total, 48'd40);
    chk("b2b_out_rec", bus.out_rec, 48'h12345678);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    bus.save_valid = 1'b1; bus.save_last = 1'b1; bus.save_inc = 7'd0;
    step();
    bus.save_valid = 1'b0;
    chk("b2b_done_total", bus.done_total, 48'd40);
    step();

    // Overflow on thread 2
    bus.req_valid = 1'b1; bus.req_thread_num = 3'd2; bus.req_new = 1'b0;
    step();
    bus.req_valid = 1'b0;
    step();
    chk("ovf_out_total", bus.out_total, 48'hFFF6);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    bus.save_valid = 1'b1; bus.save_last = 1'b0; bus.save_inc = 7'd20; bus.save_rec = 32'h0BADF00D;
    step();
    bus.save_valid = 1'b0;
    chk("ovf_din", bus.mem_din, {16'd10, 32'h0BADF00D});
    chk("ovf_err", bus.err_overflow, 48'd1);
    step(); step();
    chk("ovf_err_sticky", bus.err_overflow, 48'd1);

    // Backpressure on thread 2 with ignored save_valid in OUT
    bus.req_valid = 1'b1; bus.req_thread_num = 3'd2; bus.req_new = 1'b0;
    step();
    bus.req_valid = 1'b0;
    step();
    bus.save_valid = 1'b1; bus.save_last = 1'b1; bus.save_inc = 7'd5;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_valid", bus.out_valid, 48'd1);
      chk("bp_out_total", bus.out_total, 48'd10);
      chk("bp_out_rec", bus.out_rec, 48'h0BADF00D);
      chk("bp_no_wr", bus.mem_wr_en, 48'd0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    step();
    bus.save_valid = 1'b0;
    chk("bp_done", bus.done, 48'd1);
    chk("bp_done_total", bus.done_total, 48'd15);
    chk("bp_done_thread", bus.done_thread_num, 48'd2);
    step();

    // Reset while saving in BUSY
    bus.req_valid = 1'b1; bus.req_thread_num = 3'd1; bus.req_new = 1'b1;
    step();
    bus.req_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    bus.save_valid = 1'b1; bus.save_last = 1'b1; bus.save_inc = 7'd9;
    rst_n = 1'b0;
    step();
    bus.save_valid = 1'b0;
    chk("rb_no_wr", bus.mem_wr_en, 48'd0);
    chk("rb_no_done", bus.done, 48'd0);
    chk("rb_done_total", bus.done_total, 48'd0);
    chk("rb_err", bus.err_overflow, 48'd0);
    chk("rb_ready_low", bus.req_ready, 48'd0);
    rst_n = 1'b1;
    step();
    chk("rb_ready", bus.req_ready, 48'd1);
    chk("rb_out_valid", bus.out_valid, 48'd0);
    chk("rb_wr_after", bus.mem_wr_en, 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/procb_state_seq.md
# procb_state_seq

Per-thread sequencer for the process_bytes stage of the sha256crypt engine. It sits between the thread scheduler and the saved-state memory (distributed RAM, one word per thread, registered read with 1-cycle latency). For each request it fetches or clears a thread's saved state and hands it to the process_bytes engine. When the engine finishes the block it accumulates bytes_total, writes the state back, and reports completion when the record is finished. One thread is in flight at a time.

## Interface
- N_THREADS, `N_THREADS: number of threads / memory words.
- N_THREADS_MSB, `MSB(N_THREADS-1): thread number MSB.
- CLK  in  1  clock; all logic on posedge.
- RESET_N  in  1  synchronous, active-low reset.
- req_valid / req_ready  in / out  1  scheduler handshake.
- req_thread_num  in  N_THREADS_MSB+1  thread to start.
- req_new  in  1  fresh computation: ignore memory, start from zero state.
- out_valid / out_ready  out / in  1  handshake toward the engine.
- out_thread_num, out_total, out_rec  out  thread / `PROCB_TOTAL_WIDTH / `PROCB_REC_WIDTH  loaded state.
- save_valid  in  1  engine finished the block (honoured only in BUSY).
- save_last  in  1  record complete; clear the saved state.
- save_inc  in  7  bytes processed in this block, 0..64.
- save_rec  in  `PROCB_REC_WIDTH  unfinished record data to keep.
- done  out  1  one-cycle pulse on a save_last completion.
- done_thread_num, done_total  out  thread / `PROCB_TOTAL_WIDTH  final values, held until the next done.
- err_overflow  out  1  sticky flag; total addition wrapped.
- mem_rd_en, mem_rd_thread_num  out  1 / thread  memory read port.
- mem_dout  in  `PROCB_SAVE_WIDTH  memory read data, valid the cycle after mem_rd_en.
- mem_wr_en, mem_wr_thread_num, mem_din  out  1 / thread / `PROCB_SAVE_WIDTH  memory write port, registered.

## Operation
- Save word layout is {total, rec}, and `PROCB_SAVE_WIDTH = `PROCB_TOTAL_WIDTH + `PROCB_REC_WIDTH.
- The FSM has four states: IDLE, READ, OUT, BUSY.
  - IDLE: req_ready=1. On a handshake, latch the thread number.
    - If !req_new: mem_rd_en=1 combinationally in the same cycle, then go to READ.
    - If req_new: load total=0 and rec=0, then go to OUT.
  - READ: capture mem_dout into the out registers (or the forwarded value, see Timing), then go to OUT.
  - OUT: out_valid=1 with the data held stable. On out_valid&&out_ready, go to BUSY.
  - BUSY: on save_valid, new_total = out_total + save_inc, computed modulo 2^`PROCB_TOTAL_WIDTH.
    - If the carry out is set, set err_overflow.
    - Register the write: mem_wr_en=1 in the next cycle.
    - If save_last: mem_din is all zeros; done pulses and done_total = new_total.
    - Otherwise: mem_din = {new_total, save_rec}.
    - Go to IDLE.
- save_valid outside BUSY is ignored: no write, no state change.
- Reset values: all outputs 0, state IDLE, err_overflow 0. done_total, done_thread_num and the out_* registers are also 0.
- Reset mid-operation returns the FSM to IDLE and drops any pending write.

## Timing
- Request at cycle T, !req_new: mem_rd_en in T, capture in T+1, out_valid from T+2.
- Request at cycle T, req_new: out_valid from T+1.
- save_valid at cycle S: mem_wr_en and done in S+1. The FSM is in IDLE in S+1.
- Hazard: in S+1 the memory write and a new read of the same thread share the same edge, so the memory returns stale data.
  - With `PROCB_BYPASS_EN defined: req_ready=1 in S+1. If the new request has the same thread number as the pending write, the READ capture uses the registered mem_din instead of mem_dout.
  - Without it: req_ready=0 in S+1 (one bubble).
- out_* registers do not change while out_valid=1 and out_ready=0.

## Configuration
- The only configuration macro is `PROCB_BYPASS_EN (defined in sha256.vh).
- Defined: write-to-read forwarding; back-to-back thread turnaround with no bubble.
- Undefined: no forwarding path; req_ready is forced low in the cycle of a pending write.
- Both builds must produce identical data. They differ only in throughput.

## Structure
- In sha256.vh:
  - widths `PROCB_TOTAL_WIDTH, `PROCB_REC_WIDTH, `PROCB_SAVE_WIDTH;
  - state encodings;
  - `PROCB_BYPASS_EN.
- Natural sub-module: procb_total_add, the registered total adder with carry output that feeds err_overflow.

## Test plan
- Fresh request: req_new, thread 3, save_inc=64, not last -> mem_wr_en at S+1, thread 3, mem_din={64, save_rec}; out_valid one cycle after the request.
- Resume: preload thread 3 with total=64, request !req_new, save_inc=23, save_last -> done pulse, done_total=87, mem_din all zeros.
- Back-to-back same thread: save at S, request for the same thread at S+1.
  - With the bypass: accepted at S+1 and out_total equals the just-written total.
  - Without the bypass: req_ready=0 at S+1, request accepted at S+2, same value.
- Overflow: total=2^`PROCB_TOTAL_WIDTH-10, save_inc=20 -> new_total=10 and err_overflow=1, held until reset.
- Backpressure: out_ready=0 for 5 cycles -> out_* stable throughout. save_valid in OUT is ignored: no mem_wr_en.
- Reset in BUSY after save_valid -> no mem_wr_en, all outputs 0, req_ready=1 one cycle after RESET_N rises.
